// File: rtl/adder4_accum.sv
// adder4_accum: frames N_SAMPLES 5-bit adder results into a wide sum with a sticky overflow flag
module adder4_accum #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [7:0]       cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, base, sample;
    logic [ACC_W:0]   add;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d, in_xfer, out_xfer;
    always_comb begin
        sample   = ACC_W'({cout, sum});
        // IDLE starts a fresh frame, so the running total is treated as zero there
        base     = state_q == IDLE ? '0 : acc_q;
        add      = {1'b0, base} + {1'b0, sample};
        cnt_inc  = (state_q == IDLE ? 8'd0 : cnt_q) + 8'd1;
        in_xfer  = in_valid && state_q != DONE;
        out_xfer = out_ready && state_q == DONE;
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        if (in_xfer) begin
            acc_d   = add[ACC_W-1:0];
            ovf_d   = (state_q == ACCUM && ovf_q) || add[ACC_W];
            cnt_d   = cnt_inc;
            state_d = cnt_inc == 8'(N_SAMPLES) ? DONE : ACCUM;
        end else if (out_xfer) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready  = state_q != DONE;
    assign out_valid = state_q == DONE;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;
endmodule

// File: tb/tb_adder4_accum.sv
// tb_adder4_accum: directed vectors on N_SAMPLES=4, 10 and 1 instances of adder4_accum
module tb_adder4_accum;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] sum = 4'd0;
    logic       cout = 1'b0;
    int         sel = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic       iv [3];
    logic       ordy [3];
    logic       rdy [3];
    logic       ov [3];
    logic       of [3];
    logic [7:0] acc [3];
    logic [7:0] cn [3];
    always #5 clk = ~clk;
    always_comb for (int i = 0; i < 3; i++) begin
        iv[i]   = in_valid && sel == i;
        ordy[i] = out_ready && sel == i;
    end
    adder4_accum #(.N_SAMPLES(4), .ACC_W(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .sum(sum), .cout(cout),
        .out_valid(ov[0]), .out_ready(ordy[0]), .acc_out(acc[0]), .ovf(of[0]), .cnt(cn[0]));
    adder4_accum #(.N_SAMPLES(10), .ACC_W(8)) u10 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .sum(sum), .cout(cout),
        .out_valid(ov[1]), .out_ready(ordy[1]), .acc_out(acc[1]), .ovf(of[1]), .cnt(cn[1]));
    adder4_accum #(.N_SAMPLES(1), .ACC_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .sum(sum), .cout(cout),
        .out_valid(ov[2]), .out_ready(ordy[2]), .acc_out(acc[2]), .ovf(of[2]), .cnt(cn[2]));
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // present one sample and hold it until accepted; returns #1 after the accepting edge
    task automatic feed(input int s);
        int k;
        @(negedge clk);
        sum      = 4'(s);
        cout     = s[4];
        in_valid = 1'b1;
        k = 0;
        while (!rdy[sel] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rdy[sel]) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic gap(input int n, input int exp_cnt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("gap_cnt", cn[sel], exp_cnt);
        end
    endtask
    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_ov", ov[sel], 0);
        chk("drain_rdy", rdy[sel], 1);
    endtask
    initial begin
        #3;
        chk("rst_acc", acc[0], 0);
        chk("rst_ovf", of[0], 0);
        chk("rst_cnt", cn[0], 0);
        chk("rst_ov", ov[0], 0);
        chk("rst_rdy", rdy[0], 1);
        @(negedge clk);
        rst = 1'b0;
        // basic frame
        sel = 0;
        feed(1);
        chk("b_cnt1", cn[0], 1);
        chk("b_ov1", ov[0], 0);
        feed(2);
        feed(3);
        chk("b_acc3", acc[0], 6);
        feed(9);
        chk("b_ov", ov[0], 1);
        chk("b_acc", acc[0], 15);
        chk("b_ovf", of[0], 0);
        chk("b_cnt", cn[0], 4);
        chk("b_rdy", rdy[0], 0);
        drain();
        chk("b_clr_acc", acc[0], 0);
        chk("b_clr_cnt", cn[0], 0);
        // carry input: 12+13 = 25 four times
        for (int i = 0; i < 4; i++) feed(25);
        chk("c_acc", acc[0], 100);
        chk("c_ovf", of[0], 0);
        drain();
        // overflow on the N=10 instance
        sel = 1;
        for (int i = 0; i < 9; i++) feed(31);
        chk("o_acc9", acc[1], 23);
        chk("o_ovf9", of[1], 1);
        chk("o_ov9", ov[1], 0);
        feed(31);
        chk("o_acc", acc[1], 54);
        chk("o_ovf", of[1], 1);
        chk("o_ov", ov[1], 1);
        chk("o_cnt", cn[1], 10);
        drain();
        chk("o_clr_ovf", of[1], 0);
        for (int i = 0; i < 4; i++) feed(1);
        chk("o2_acc", acc[1], 4);
        chk("o2_ovf", of[1], 0);
        for (int i = 0; i < 6; i++) feed(1);
        chk("o3_acc", acc[1], 10);
        chk("o3_ov", ov[1], 1);
        drain();
        // bubbles and backpressure
        sel = 0;
        feed(2);
        gap(3, 1);
        feed(3);
        gap(3, 2);
        chk("p_acc_gap", acc[0], 5);
        feed(4);
        out_ready = 1'b0;
        feed(5);
        in_valid = 1'b1;
        sum      = 4'hF;
        cout     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("p_ov", ov[0], 1);
            chk("p_acc", acc[0], 14);
            chk("p_ovf", of[0], 0);
            chk("p_rdy", rdy[0], 0);
        end
        in_valid = 1'b0;
        drain();
        chk("p_idle_acc", acc[0], 0);
        // reset mid-frame
        feed(1);
        feed(1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_acc", acc[0], 0);
        chk("r_cnt", cn[0], 0);
        chk("r_ov", ov[0], 0);
        chk("r_rdy", rdy[0], 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) feed(1);
        chk("r2_acc", acc[0], 4);
        chk("r2_ov", ov[0], 1);
        drain();
        // reset while holding a frame in DONE
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(7);
        chk("rd_ov", ov[0], 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rd_ov_clr", ov[0], 0);
        chk("rd_acc_clr", acc[0], 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        // single-sample frames
        sel = 2;
        chk("s_ov0", ov[2], 0);
        feed(17);
        chk("s_ov", ov[2], 1);
        chk("s_acc", acc[2], 17);
        chk("s_cnt", cn[2], 1);
        drain();
        feed(5);
        chk("s2_acc", acc[2], 5);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
